// File: rtl/mem_wb_if.sv
// Bundle of MEM-stage inputs and registered WB-stage outputs for mem_wb.
// MEMWB_FLUSH_EN adds the synchronous flush input.
interface mem_wb_if #(
   parameter int DATA_W = 16,
   parameter int OP_W   = 4,
   parameter int RW_W   = 3
);
   logic              of;
   logic [DATA_W-1:0] rd, ALUout, rd1, rd15;
   logic [OP_W-1:0]   op1, op2;
   logic [RW_W-1:0]   regWrite;
   logic              F;
`ifdef MEMWB_FLUSH_EN
   logic              flush;
`endif
   logic [DATA_W-1:0] memwbRD, memwbALUout, memwbRD1, memwbRD15;
   logic [OP_W-1:0]   memwbOP1, memwbOP2;
   logic [RW_W-1:0]   memwbregWrite;
   logic              memwbF;

   modport master (
      output of, rd, ALUout, rd1, rd15, op1, op2, regWrite, F,
`ifdef MEMWB_FLUSH_EN
      output flush,
`endif
      input  memwbRD, memwbALUout, memwbRD1, memwbRD15, memwbOP1, memwbOP2,
             memwbregWrite, memwbF
   );

   modport slave (
      input  of, rd, ALUout, rd1, rd15, op1, op2, regWrite, F,
`ifdef MEMWB_FLUSH_EN
      input  flush,
`endif
      output memwbRD, memwbALUout, memwbRD1, memwbRD15, memwbOP1, memwbOP2,
             memwbregWrite, memwbF
   );
endinterface

// File: rtl/mem_wb.sv
// MEM/WB pipeline register: one-cycle capture, overflow squashes regWrite.
// MEMWB_FLUSH_EN adds a synchronous flush that loads a bubble.
module mem_wb #(
   parameter int DATA_W = 16,
   parameter int OP_W   = 4,
   parameter int RW_W   = 3
) (
   input logic    clk,
   input logic    reset,
   mem_wb_if.slave bus
);
   typedef struct packed {
      logic [DATA_W-1:0] rd;
      logic [DATA_W-1:0] alu;
      logic [DATA_W-1:0] rd1;
      logic [DATA_W-1:0] rd15;
      logic [OP_W-1:0]   op1;
      logic [OP_W-1:0]   op2;
      logic [RW_W-1:0]   rw;
      logic              f;
   } stage_t;

   stage_t nxt, q;

   always_comb begin
      nxt      = '0;
      nxt.rd   = bus.rd;
      nxt.alu  = bus.ALUout;
      nxt.rd1  = bus.rd1;
      nxt.rd15 = bus.rd15;
      nxt.op1  = bus.op1;
      nxt.op2  = bus.op2;
      nxt.f    = bus.F;
      // Undriven of must not kill the write, so only a solid 1 squashes.
      nxt.rw   = (bus.of === 1'b1) ? '0 : bus.regWrite;
`ifdef MEMWB_FLUSH_EN
      if (bus.flush) nxt = '0;
`endif
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) q <= '0;
      else        q <= nxt;
   end

   assign bus.memwbRD       = q.rd;
   assign bus.memwbALUout   = q.alu;
   assign bus.memwbRD1      = q.rd1;
   assign bus.memwbRD15     = q.rd15;
   assign bus.memwbOP1      = q.op1;
   assign bus.memwbOP2      = q.op2;
   assign bus.memwbregWrite = q.rw;
   assign bus.memwbF        = q.f;
endmodule

// File: tb/tb_mem_wb.sv
// Directed + random bench for mem_wb with a field-level reference model.
module tb_mem_wb;
   logic clk = 1'b0;
   logic reset;
   int   n_tests = 0;
   int   n_fail  = 0;

   mem_wb_if #(.DATA_W(16), .OP_W(4), .RW_W(3)) bus ();
   mem_wb #(.DATA_W(16), .OP_W(4), .RW_W(3)) dut (.clk(clk), .reset(reset), .bus(bus));

   always #5 clk = ~clk;

   // reference state: what the WB stage should see
   logic [15:0] e_rd, e_alu, e_rd1, e_rd15;
   logic [3:0]  e_op1, e_op2;
   logic [2:0]  e_rw;
   logic        e_f;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
      n_tests++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic chk_all(input string tag);
      chk({tag, ".RD"},    bus.memwbRD,              e_rd);
      chk({tag, ".ALU"},   bus.memwbALUout,          e_alu);
      chk({tag, ".RD1"},   bus.memwbRD1,             e_rd1);
      chk({tag, ".RD15"},  bus.memwbRD15,            e_rd15);
      chk({tag, ".OP1"},   {12'h0, bus.memwbOP1},    {12'h0, e_op1});
      chk({tag, ".OP2"},   {12'h0, bus.memwbOP2},    {12'h0, e_op2});
      chk({tag, ".RW"},    {13'h0, bus.memwbregWrite}, {13'h0, e_rw});
      chk({tag, ".F"},     {15'h0, bus.memwbF},      {15'h0, e_f});
   endtask

   task automatic model_clear();
      e_rd = '0; e_alu = '0; e_rd1 = '0; e_rd15 = '0;
      e_op1 = '0; e_op2 = '0; e_rw = '0; e_f = 1'b0;
   endtask

   task automatic set_in(input logic o, input logic [15:0] a, input logic [15:0] r,
                         input logic [15:0] r1, input logic [15:0] r15,
                         input logic [3:0] p1, input logic [3:0] p2,
                         input logic [2:0] rw, input logic f);
      bus.of = o; bus.ALUout = a; bus.rd = r; bus.rd1 = r1; bus.rd15 = r15;
      bus.op1 = p1; bus.op2 = p2; bus.regWrite = rw; bus.F = f;
   endtask

   task automatic set_rand();
      set_in(1'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
             4'($urandom), 4'($urandom), 3'($urandom), 1'($urandom));
   endtask

   // One rising edge; the model captures the inputs the DUT saw, then outputs are checked.
   task automatic step(input string tag);
      @(posedge clk);
      if (!reset) model_clear();
      else begin
         e_rd = bus.rd; e_alu = bus.ALUout; e_rd1 = bus.rd1; e_rd15 = bus.rd15;
         e_op1 = bus.op1; e_op2 = bus.op2; e_f = bus.F;
         e_rw = (bus.of === 1'b1) ? 3'b000 : bus.regWrite;
      end
      #1 chk_all(tag);
   endtask

   initial begin
`ifdef MEMWB_FLUSH_EN
      bus.flush = 1'b0;
`endif
      reset = 1'b0;
      set_rand();
      model_clear();
      #1 chk_all("reset_t1");
      #2 set_rand();
      #2 chk_all("reset_t5");
      for (int i = 0; i < 3; i++) begin
         @(negedge clk) set_rand();
         step("reset_hold");
      end

      @(negedge clk);
      reset = 1'b1;
      set_in(1'b0, 16'hA0A0, 16'h0A0A, 16'h1234, 16'h0098, 4'b0001, 4'b0010, 3'b001, 1'b0);
      step("basic");

      @(negedge clk);
      set_in(1'b0, 16'h1BEA, 16'h0BEA, 16'h4321, 16'h1BEA, 4'b0000, 4'b1111, 3'b100, 1'b1);
      #1 chk_all("update_hold");
      step("update");

      @(negedge clk) bus.of = 1'b1;
      step("ovf_squash");
      @(negedge clk) bus.of = 1'b0;
      step("ovf_clear");

      @(negedge clk) begin bus.of = 1'bx; bus.regWrite = 3'b001; end
      step("of_x");

      for (int i = 0; i < 40; i++) begin
         @(negedge clk) set_rand();
         step("rand");
      end

      // async reset between edges while outputs are nonzero
      @(negedge clk) set_in(1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 4'hF, 4'hF, 3'b111, 1'b1);
      step("pre_async");
      #2 reset = 1'b0;
      model_clear();
      #1 chk_all("async_rst");
      @(negedge clk) set_rand();
      step("rst_ignore");
      @(negedge clk) begin
         reset = 1'b1;
         set_in(1'b0, 16'h5555, 16'hAAAA, 16'h0F0F, 16'hF0F0, 4'h3, 4'hC, 3'b010, 1'b1);
      end
      step("resume");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
